johnson_phase_monitor: RTL and testbench

Downstream consumer of the 4-bit Johnson counter output. It decodes the 8-state Johnson code into a phase index and a one-hot phase vector. It also checks that every new code is the legal successor of the previous one, and counts completed 8-phase cycles. Its outputs drive phase-enable logic and a fault LED, and it flags any corrupted or skipped counter state.

---
 rtl/johnson_phase_monitor_if.sv | 30 +++
 rtl/johnson_phase_monitor.sv | 113 +++++++++++
 tb/tb_johnson_phase_monitor.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/johnson_phase_monitor_if.sv
// Johnson phase monitor bus: sample inputs from the counter side,
// decoded phase, sticky error flags and cycle count back out.
interface johnson_phase_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [3:0]       jc_in;
  logic             clr_err;
  logic [2:0]       phase_idx;
  logic [7:0]       phase_oh;
  logic             valid;
  logic             err_illegal;
  logic             err_seq;
  logic [CNT_W-1:0] cycle_cnt;
  logic             cyc_pulse;

  modport master (
    output en, jc_in, clr_err,
    input  phase_idx, phase_oh, valid,
    input  err_illegal, err_seq,
    input  cycle_cnt, cyc_pulse
  );

  modport slave (
    input  en, jc_in, clr_err,
    output phase_idx, phase_oh, valid,
    output err_illegal, err_seq,
    output cycle_cnt, cyc_pulse
  );
endinterface

// File: rtl/johnson_phase_monitor.sv
// Decodes a 4-bit Johnson code to phase, checks successor order,
// counts 7->0 wraps. Ports: clk, rst (sync, active-low), bus m.
module johnson_phase_monitor #(
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  johnson_phase_monitor_if.slave m
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } st_t;

  st_t              st;
  st_t              cur;
  logic             legal;
  logic [2:0]       ph;
  logic [2:0]       succ;
  logic [2:0]       idx_q;
  logic [7:0]       oh_q;
  logic             val_q;
  logic             ill_q;
  logic             seq_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cyc_q;

  always_comb begin
    legal = 1'b1;
    ph    = 3'd0;
    unique case (m.jc_in)
      4'b0000: ph = 3'd0;
      4'b1000: ph = 3'd1;
      4'b1100: ph = 3'd2;
      4'b1110: ph = 3'd3;
      4'b1111: ph = 3'd4;
      4'b0111: ph = 3'd5;
      4'b0011: ph = 3'd6;
      4'b0001: ph = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // clr_err turns this sample into a fresh INIT sample
  assign cur  = m.clr_err ? INIT : st;
  assign succ = idx_q + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st    <= INIT;
      idx_q <= '0;
      oh_q  <= '0;
      val_q <= 1'b0;
      ill_q <= 1'b0;
      seq_q <= 1'b0;
      cnt_q <= '0;
      cyc_q <= 1'b0;
    end else if (!m.en) begin
      cyc_q <= 1'b0;
    end else begin
      cyc_q <= 1'b0;
      val_q <= legal;
      oh_q  <= legal ? (8'd1 << ph) : 8'd0;
      if (legal)
        idx_q <= ph;
      // later set assignments below override this clear
      if (m.clr_err) begin
        ill_q <= 1'b0;
        seq_q <= 1'b0;
      end
      unique case (cur)
        INIT: begin
          if (legal) begin
            st <= TRACK;
          end else begin
            st    <= FAULT;
            ill_q <= 1'b1;
          end
        end
        TRACK: begin
          if (!legal) begin
            st    <= FAULT;
            ill_q <= 1'b1;
          end else if (ph == idx_q) begin
            st <= TRACK;
          end else if (ph == succ) begin
            st <= TRACK;
            if (idx_q == 3'd7) begin
              cnt_q <= cnt_q + 1'b1;
              cyc_q <= 1'b1;
            end
          end else begin
            st    <= FAULT;
            seq_q <= 1'b1;
          end
        end
        FAULT: st <= FAULT;
        default: st <= INIT;
      endcase
    end
  end

  assign m.phase_idx   = idx_q;
  assign m.phase_oh    = oh_q;
  assign m.valid       = val_q;
  assign m.err_illegal = ill_q;
  assign m.err_seq     = seq_q;
  assign m.cycle_cnt   = cnt_q;
  assign m.cyc_pulse   = cyc_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Bench for johnson_phase_monitor: vector table, corner sequences,
// and random stimulus against a phase-level reference model.
module tb_johnson_phase_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  johnson_phase_monitor_if #(.CNT_W(8)) m1 ();
  johnson_phase_monitor_if #(.CNT_W(2)) m2 ();

  assign m2.en      = m1.en;
  assign m2.jc_in   = m1.jc_in;
  assign m2.clr_err = m1.clr_err;

  johnson_phase_monitor #(.CNT_W(8)) u1 (
    .clk (clk),
    .rst (rst),
    .m   (m1.slave)
  );

  johnson_phase_monitor #(.CNT_W(2)) u2 (
    .clk (clk),
    .rst (rst),
    .m   (m2.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [3:0] codes [8] = '{4'h0, 4'h8, 4'hC, 4'hE,
                            4'hF, 4'h7, 4'h3, 4'h1};

  // reference model state
  bit mvalid, mill, mseq, mpul, mfault, mtrack;
  int midx, mcnt;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic bit dec(logic [3:0] j, output int p);
    p = 0;
    for (int i = 0; i < 8; i++)
      if (codes[i] == j) begin
        p = i;
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model(bit r, bit e, bit c, logic [3:0] j);
    int p;
    bit ok;
    if (!r) begin
      mvalid = 0; mill = 0; mseq = 0; mpul = 0;
      mfault = 0; mtrack = 0; midx = 0; mcnt = 0;
    end else if (!e) begin
      mpul = 0;
    end else begin
      mpul = 0;
      if (c) begin
        mill = 0; mseq = 0; mfault = 0; mtrack = 0;
      end
      ok = dec(j, p);
      if (!mfault) begin
        if (!ok) begin
          mill = 1; mfault = 1;
        end else if (mtrack && p != midx && p != (midx + 1) % 8) begin
          mseq = 1; mfault = 1;
        end else if (mtrack && midx == 7 && p == 0) begin
          mcnt++; mpul = 1;
        end
        if (!mfault) mtrack = 1;
      end
      mvalid = ok;
      if (ok) midx = p;
    end
  endtask

  task automatic mchk();
    chk("idx", int'(m1.phase_idx), midx);
    chk("oh", int'(m1.phase_oh), mvalid ? (1 << midx) : 0);
    chk("valid", int'(m1.valid), int'(mvalid));
    chk("err_ill", int'(m1.err_illegal), int'(mill));
    chk("err_seq", int'(m1.err_seq), int'(mseq));
    chk("cnt8", int'(m1.cycle_cnt), mcnt % 256);
    chk("pulse8", int'(m1.cyc_pulse), int'(mpul));
    chk("cnt2", int'(m2.cycle_cnt), mcnt % 4);
    chk("pulse2", int'(m2.cyc_pulse), int'(mpul));
  endtask

  task automatic cyc(bit r, bit e, bit c, logic [3:0] j);
    rst        = r;
    m1.en      = e;
    m1.clr_err = c;
    m1.jc_in   = j;
    @(posedge clk);
    model(r, e, c, j);
    #1;
    mchk();
  endtask

  typedef struct {
    bit r, e, c;
    logic [3:0] j;
    int idx;
    bit val, ill, seq;
    int cnt;
    bit pul;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit e, bit c, logic [3:0] j,
                              int idx, bit val, bit ill, bit seq,
                              int cnt, bit pul);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.j = j;
    v.idx = idx; v.val = val; v.ill = ill; v.seq = seq;
    v.cnt = cnt; v.pul = pul;
    tbl.push_back(v);
  endfunction

  initial begin
    int p, k, npul, r;
    logic [3:0] j;
    int exp2 [5] = '{1, 2, 3, 0, 1};
    m1.en = 0; m1.clr_err = 0; m1.jc_in = 4'h1;

    // free run from reset
    add(0,1,0,4'h1, 0,0,0,0, 0,0);
    add(1,1,0,4'h1, 7,1,0,0, 0,0);
    add(1,1,0,4'h0, 0,1,0,0, 1,1);
    add(1,1,0,4'h8, 1,1,0,0, 1,0);
    add(1,1,0,4'hC, 2,1,0,0, 1,0);
    add(1,1,0,4'hE, 3,1,0,0, 1,0);
    add(1,1,0,4'hF, 4,1,0,0, 1,0);
    add(1,1,0,4'h7, 5,1,0,0, 1,0);
    add(1,1,0,4'h3, 6,1,0,0, 1,0);
    add(1,1,0,4'h1, 7,1,0,0, 1,0);
    add(1,1,0,4'h0, 0,1,0,0, 2,1);
    // hold at 1100
    add(1,1,0,4'h8, 1,1,0,0, 2,0);
    for (int i = 0; i < 5; i++)
      add(1,1,0,4'hC, 2,1,0,0, 2,0);
    add(1,1,0,4'hE, 3,1,0,0, 2,0);
    // illegal, frozen count, clear and resume
    add(1,1,0,4'h5, 3,0,1,0, 2,0);
    add(1,1,0,4'hF, 4,1,1,0, 2,0);
    add(1,1,0,4'h7, 5,1,1,0, 2,0);
    add(1,1,0,4'h3, 6,1,1,0, 2,0);
    add(1,1,0,4'h1, 7,1,1,0, 2,0);
    add(1,1,0,4'h0, 0,1,1,0, 2,0);
    add(1,1,1,4'h8, 1,1,0,0, 2,0);
    add(1,1,0,4'hC, 2,1,0,0, 2,0);
    add(1,1,0,4'hE, 3,1,0,0, 2,0);
    add(1,1,0,4'hF, 4,1,0,0, 2,0);
    add(1,1,0,4'h7, 5,1,0,0, 2,0);
    add(1,1,0,4'h3, 6,1,0,0, 2,0);
    add(1,1,0,4'h1, 7,1,0,0, 2,0);
    add(1,1,0,4'h0, 0,1,0,0, 3,1);
    // skip 0000 -> 1100, then clear with illegal
    add(1,1,0,4'hC, 2,1,0,1, 3,0);
    add(1,1,1,4'hA, 2,0,1,0, 3,0);
    add(1,1,1,4'hE, 3,1,0,0, 3,0);
    // en low while code moves, then successor
    add(1,0,0,4'h0, 3,1,0,0, 3,0);
    add(1,0,0,4'h8, 3,1,0,0, 3,0);
    add(1,0,1,4'h5, 3,1,0,0, 3,0);
    add(1,1,0,4'hF, 4,1,0,0, 3,0);
    // reset mid-track wins over en=0 and clr_err
    add(0,0,1,4'h0, 0,0,0,0, 0,0);

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].j);
      chk("t_idx", int'(m1.phase_idx), tbl[i].idx);
      chk("t_oh", int'(m1.phase_oh),
          tbl[i].val ? (1 << tbl[i].idx) : 0);
      chk("t_valid", int'(m1.valid), int'(tbl[i].val));
      chk("t_ill", int'(m1.err_illegal), int'(tbl[i].ill));
      chk("t_seq", int'(m1.err_seq), int'(tbl[i].seq));
      chk("t_cnt", int'(m1.cycle_cnt), tbl[i].cnt);
      chk("t_pul", int'(m1.cyc_pulse), int'(tbl[i].pul));
    end

    // narrow counter wraps after four cycles
    cyc(0, 1, 0, 4'h1);
    cyc(1, 1, 0, 4'h1);
    npul = 0;
    for (int n = 0; n < 5; n++)
      for (int q = 0; q < 8; q++) begin
        cyc(1, 1, 0, codes[q]);
        if (m2.cyc_pulse) npul++;
        if (q == 0) chk("w2_cnt", int'(m2.cycle_cnt), exp2[n]);
      end
    chk("w2_pulses", npul, 5);
    chk("w8_cnt", int'(m1.cycle_cnt), 5);

    // random walk
    p = 7;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      k = 0;
      if (r < 2) begin
        p = 7;
        cyc(0, 1, 0, codes[7]);
        continue;
      end else if (r < 10) begin
        j = codes[$urandom_range(0, 7)];
        cyc(1, 0, ($urandom_range(0, 3) == 0), j);
        continue;
      end else if (r < 14) begin
        do j = 4'($urandom_range(0, 15)); while (dec(j, k));
      end else if (r < 20) begin
        p = $urandom_range(0, 7);
        j = codes[p];
      end else if (r < 35) begin
        j = codes[p];
      end else begin
        p = (p + 1) % 8;
        j = codes[p];
      end
      cyc(1, 1, ($urandom_range(0, 24) == 0), j);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
